reorder_buffer: RTL and testbench

- Circular in-order retirement queue for the Tomasulo core; drives the commit and flush side of the register-rename interface.
- Dispatcher allocates entries and reads operand status. CDB results mark entries ready.
- Head entries retire one per cycle to the register file.
- A mispredicted branch at the head raises a one-cycle refresh that flushes the ROB, the register busy table and the CDB consumers.

---
 rtl/reorder_buffer_pkg.sv | 13 +
 rtl/reorder_buffer.sv | 173 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants for the reorder buffer and its rename/CDB neighbours.
package reorder_buffer_pkg;

  localparam int DEF_ROB_WIDTH  = 4;
  localparam int DEF_ROB_SIZE   = 1 << DEF_ROB_WIDTH;
  localparam int DEF_REG_WIDTH  = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: dispatch allocates at the tail, the CDB marks
// entries ready, the head retires one entry per cycle and a mispredicted branch flushes all.
//
// Handshake: no ready/valid back-pressure. alloc_dp_in is accepted on any edge with
// rdy_in=1 and full_dp_out=0; cdb_valid_in is accepted whenever the target entry is valid;
// rdy_commit_rob_out and refresh_rob_cdb_out are single-cycle pulses with no acknowledge.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH  = DEF_ROB_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  alloc_dp_in,
  input  logic [REG_WIDTH-1:0]  rd_dp_in,
  input  logic                  is_branch_dp_in,
  input  logic                  pred_taken_dp_in,
  output logic                  full_dp_out,
  output logic [ROB_WIDTH-1:0]  alloc_id_dp_out,
  input  logic [ROB_WIDTH-1:0]  rs1_rob_dp_in,
  input  logic [ROB_WIDTH-1:0]  rs2_rob_dp_in,
  output logic                  rs1_ready_dp_out,
  output logic                  rs2_ready_dp_out,
  output logic [DATA_WIDTH-1:0] rs1_val_dp_out,
  output logic [DATA_WIDTH-1:0] rs2_val_dp_out,
  input  logic                  cdb_valid_in,
  input  logic [ROB_WIDTH-1:0]  cdb_rob_in,
  input  logic [DATA_WIDTH-1:0] cdb_val_in,
  input  logic                  cdb_taken_in,
  input  logic [ADDR_WIDTH-1:0] cdb_target_in,
  output logic                  rdy_commit_rob_out,
  output logic [REG_WIDTH-1:0]  dest_rob_out,
  output logic [DATA_WIDTH-1:0] value_rob_out,
  output logic [ROB_WIDTH-1:0]  rob_id_rob_out,
  output logic                  refresh_rob_cdb_out,
  output logic [ADDR_WIDTH-1:0] pc_redirect_out
);

  localparam int ROB_SIZE = 1 << ROB_WIDTH;

  typedef logic [ROB_WIDTH-1:0] id_t;
  typedef logic [ROB_WIDTH:0]   cnt_t;

  typedef struct packed {
    logic [REG_WIDTH-1:0]  rd;
    logic                  is_branch;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] value;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target;
  } entry_t;

  logic [ROB_SIZE-1:0] valid_q;
  logic [ROB_SIZE-1:0] ready_q;
  entry_t              ent_q [ROB_SIZE];
  id_t                 head_q;
  id_t                 tail_q;
  cnt_t                count_q;
  cnt_t                count_d;

  logic   alloc_fire;
  logic   cdb_hit;
  logic   commit_fire;
  logic   mispredict;
  entry_t head_ent;

  assign full_dp_out     = (count_q == cnt_t'(ROB_SIZE));
  assign alloc_id_dp_out = tail_q;

  // ready_q only reflects edges already taken, which gives the one-cycle CDB-to-commit latency.
  assign head_ent    = ent_q[head_q];
  assign alloc_fire  = alloc_dp_in && !full_dp_out;
  assign cdb_hit     = cdb_valid_in && valid_q[cdb_rob_in];
  assign commit_fire = (count_q != '0) && ready_q[head_q];
  assign mispredict  = commit_fire && head_ent.is_branch &&
                       (head_ent.taken != head_ent.pred_taken);

  always_comb begin
    count_d = count_q;
    unique case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Operand query with CDB bypass so a broadcast this cycle is visible to dispatch.
  always_comb begin
    rs1_ready_dp_out = ready_q[rs1_rob_dp_in];
    rs1_val_dp_out   = ent_q[rs1_rob_dp_in].value;
    rs2_ready_dp_out = ready_q[rs2_rob_dp_in];
    rs2_val_dp_out   = ent_q[rs2_rob_dp_in].value;
    if (cdb_valid_in && (cdb_rob_in == rs1_rob_dp_in)) begin
      rs1_ready_dp_out = TRUE;
      rs1_val_dp_out   = cdb_val_in;
    end
    if (cdb_valid_in && (cdb_rob_in == rs2_rob_dp_in)) begin
      rs2_ready_dp_out = TRUE;
      rs2_val_dp_out   = cdb_val_in;
    end
  end

  // Control state, pointers and registered commit/flush outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      valid_q             <= '0;
      ready_q             <= '0;
      rdy_commit_rob_out  <= FALSE;
      dest_rob_out        <= '0;
      value_rob_out       <= '0;
      rob_id_rob_out      <= '0;
      refresh_rob_cdb_out <= FALSE;
      pc_redirect_out     <= '0;
    end else if (rdy_in) begin
      rdy_commit_rob_out  <= commit_fire && (head_ent.rd != '0);
      refresh_rob_cdb_out <= mispredict;
      if (commit_fire) begin
        rob_id_rob_out <= head_q;
        dest_rob_out   <= head_ent.rd;
        value_rob_out  <= head_ent.value;
      end
      if (mispredict) begin
        pc_redirect_out <= head_ent.target;
        head_q          <= '0;
        tail_q          <= '0;
        count_q         <= '0;
        valid_q         <= '0;
        ready_q         <= '0;
      end else begin
        if (cdb_hit) begin
          ready_q[cdb_rob_in] <= TRUE;
        end
        if (commit_fire) begin
          valid_q[head_q] <= FALSE;
          head_q          <= head_q + id_t'(1);
        end
        if (alloc_fire) begin
          valid_q[tail_q] <= TRUE;
          ready_q[tail_q] <= FALSE;
          tail_q          <= tail_q + id_t'(1);
        end
        count_q <= count_d;
      end
    end else begin
      rdy_commit_rob_out  <= FALSE;
      refresh_rob_cdb_out <= FALSE;
    end
  end

  // Entry payload needs no reset: it is only read once the matching valid/ready bit is set.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && !mispredict) begin
      if (alloc_fire) begin
        ent_q[tail_q].rd         <= rd_dp_in;
        ent_q[tail_q].is_branch  <= is_branch_dp_in;
        ent_q[tail_q].pred_taken <= pred_taken_dp_in;
      end
      if (cdb_hit) begin
        ent_q[cdb_rob_in].value  <= cdb_val_in;
        ent_q[cdb_rob_in].taken  <= cdb_taken_in;
        ent_q[cdb_rob_in].target <= cdb_target_in;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed table, hand sequences for the
// multi-cycle corners, and randomized traffic against a queue-based reference model.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        alloc_dp_in;
  logic [4:0]  rd_dp_in;
  logic        is_branch_dp_in;
  logic        pred_taken_dp_in;
  logic        full_dp_out;
  logic [3:0]  alloc_id_dp_out;
  logic [3:0]  rs1_rob_dp_in;
  logic [3:0]  rs2_rob_dp_in;
  logic        rs1_ready_dp_out;
  logic        rs2_ready_dp_out;
  logic [31:0] rs1_val_dp_out;
  logic [31:0] rs2_val_dp_out;
  logic        cdb_valid_in;
  logic [3:0]  cdb_rob_in;
  logic [31:0] cdb_val_in;
  logic        cdb_taken_in;
  logic [31:0] cdb_target_in;
  logic        rdy_commit_rob_out;
  logic [4:0]  dest_rob_out;
  logic [31:0] value_rob_out;
  logic [3:0]  rob_id_rob_out;
  logic        refresh_rob_cdb_out;
  logic [31:0] pc_redirect_out;

  // clock / reset
  always #5 clk_in = ~clk_in;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_dp_in(alloc_dp_in), .rd_dp_in(rd_dp_in),
    .is_branch_dp_in(is_branch_dp_in), .pred_taken_dp_in(pred_taken_dp_in),
    .full_dp_out(full_dp_out), .alloc_id_dp_out(alloc_id_dp_out),
    .rs1_rob_dp_in(rs1_rob_dp_in), .rs2_rob_dp_in(rs2_rob_dp_in),
    .rs1_ready_dp_out(rs1_ready_dp_out), .rs2_ready_dp_out(rs2_ready_dp_out),
    .rs1_val_dp_out(rs1_val_dp_out), .rs2_val_dp_out(rs2_val_dp_out),
    .cdb_valid_in(cdb_valid_in), .cdb_rob_in(cdb_rob_in), .cdb_val_in(cdb_val_in),
    .cdb_taken_in(cdb_taken_in), .cdb_target_in(cdb_target_in),
    .rdy_commit_rob_out(rdy_commit_rob_out), .dest_rob_out(dest_rob_out),
    .value_rob_out(value_rob_out), .rob_id_rob_out(rob_id_rob_out),
    .refresh_rob_cdb_out(refresh_rob_cdb_out), .pc_redirect_out(pc_redirect_out)
  );

  // reference model: program-order list of live instructions
  typedef struct {
    int          id;
    logic [4:0]  rd;
    bit          br;
    bit          pt;
    bit          rdy;
    bit          tk;
    logic [31:0] val;
    logic [31:0] tgt;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_tail;
  logic [40:0] exp_q[$];   // {rob_id, rd, value} of each expected retirement
  bit          e_commit;
  bit          e_refresh;
  logic [31:0] e_pc;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  pre_aid;
  logic        pre_full;
  logic        pre_r1;
  logic        pre_r2;
  logic [31:0] pre_v1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_query(input string name, input logic [3:0] q, input logic act_r,
                             input logic [31:0] act_v, input bit cv, input logic [3:0] cid,
                             input logic [31:0] cval);
    if (cv && cid == q) begin
      chk({name, "_bypass_ready"}, act_r, 1);
      chk({name, "_bypass_val"}, act_v, cval);
    end else begin
      foreach (mq[i]) begin
        if (mq[i].id == int'(q)) begin
          chk({name, "_ready"}, act_r, mq[i].rdy);
          if (mq[i].rdy) chk({name, "_val"}, act_v, mq[i].val);
        end
      end
    end
  endtask

  // driver: one clock of stimulus, comb checks before the edge, registered checks after
  task automatic step(input bit r, input bit a, input logic [4:0] rd, input bit br, input bit pt,
                      input logic [3:0] q1, input logic [3:0] q2, input bit cv,
                      input logic [3:0] cid, input logic [31:0] cval, input bit ctk,
                      input logic [31:0] ctgt);
    bit     fire, mis, was_full;
    m_ent_t e;
    logic [40:0] rec;
    rdy_in = r; alloc_dp_in = a; rd_dp_in = rd; is_branch_dp_in = br; pred_taken_dp_in = pt;
    rs1_rob_dp_in = q1; rs2_rob_dp_in = q2; cdb_valid_in = cv; cdb_rob_in = cid;
    cdb_val_in = cval; cdb_taken_in = ctk; cdb_target_in = ctgt;
    #1;
    chk("full", full_dp_out, mq.size() == 16);
    chk("alloc_id", alloc_id_dp_out, m_tail);
    check_query("rs1", q1, rs1_ready_dp_out, rs1_val_dp_out, cv, cid, cval);
    check_query("rs2", q2, rs2_ready_dp_out, rs2_val_dp_out, cv, cid, cval);
    pre_aid = alloc_id_dp_out; pre_full = full_dp_out;
    pre_r1 = rs1_ready_dp_out; pre_v1 = rs1_val_dp_out; pre_r2 = rs2_ready_dp_out;
    @(posedge clk_in);
    fire = r && mq.size() > 0 && mq[0].rdy;
    mis  = fire && mq[0].br && (mq[0].tk != mq[0].pt);
    e_commit  = fire && mq[0].rd != 0;
    e_refresh = mis;
    if (fire) exp_q.push_back({4'(mq[0].id), mq[0].rd, mq[0].val});
    if (mis) e_pc = mq[0].tgt;
    if (r) begin
      if (mis) begin
        mq.delete();
        m_tail = 0;
      end else begin
        was_full = (mq.size() == 16);
        if (cv) begin
          foreach (mq[i]) begin
            if (mq[i].id == int'(cid)) begin
              e = mq[i]; e.rdy = 1; e.val = cval; e.tk = ctk; e.tgt = ctgt; mq[i] = e;
            end
          end
        end
        if (fire) void'(mq.pop_front());
        if (a && !was_full) begin
          e = '{id: m_tail, rd: rd, br: br, pt: pt, rdy: 0, tk: 0, val: 0, tgt: 0};
          mq.push_back(e);
          m_tail = (m_tail + 1) % 16;
        end
      end
    end
    #1;
    chk("commit_pulse", rdy_commit_rob_out, e_commit);
    chk("refresh_pulse", refresh_rob_cdb_out, e_refresh);
    if (exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      chk("commit_rob_id", rob_id_rob_out, rec[40:37]);
      chk("commit_dest", dest_rob_out, rec[36:32]);
      chk("commit_value", value_rob_out, rec[31:0]);
    end
    if (e_refresh) chk("pc_redirect", pc_redirect_out, e_pc);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input logic [4:0] rd, input bit br, input bit pt);
    step(1, 1, rd, br, pt, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cdb(input logic [3:0] id, input logic [31:0] v, input bit tk, input logic [31:0] tgt);
    step(1, 0, 0, 0, 0, 0, 0, 1, id, v, tk, tgt);
  endtask

  task automatic do_reset();
    rst_in = 0; rdy_in = $urandom_range(0, 1); alloc_dp_in = 1; rd_dp_in = 5'd9;
    is_branch_dp_in = 0; pred_taken_dp_in = 0; rs1_rob_dp_in = 0; rs2_rob_dp_in = 0;
    cdb_valid_in = 0; cdb_rob_in = 0; cdb_val_in = 0; cdb_taken_in = 0; cdb_target_in = 0;
    @(posedge clk_in);
    mq.delete(); exp_q.delete(); m_tail = 0;
    #1;
    chk("rst_commit", rdy_commit_rob_out, 0);
    chk("rst_refresh", refresh_rob_cdb_out, 0);
    chk("rst_dest", dest_rob_out, 0);
    chk("rst_value", value_rob_out, 0);
    chk("rst_rob_id", rob_id_rob_out, 0);
    chk("rst_pc", pc_redirect_out, 0);
    chk("rst_alloc_id", alloc_id_dp_out, 0);
    chk("rst_full", full_dp_out, 0);
    rst_in = 1;
  endtask

  typedef struct {
    bit          alloc;
    logic [4:0]  rd;
    bit          cv;
    logic [3:0]  cid;
    logic [31:0] cval;
    logic [3:0]  e_aid;
    bit          e_commit;
    logic [4:0]  e_dest;
    logic [31:0] e_val;
    logic [3:0]  e_id;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 5'd3, 1'b0, 4'd0, 32'h00, 4'd0, 1'b0, 5'd0, 32'h00, 4'd0};
    tbl[1]  = '{1'b0, 5'd0, 1'b1, 4'd0, 32'h55, 4'd1, 1'b0, 5'd0, 32'h00, 4'd0};
    tbl[2]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h00, 4'd1, 1'b1, 5'd3, 32'h55, 4'd0};
    tbl[3]  = '{1'b1, 5'd1, 1'b0, 4'd0, 32'h00, 4'd1, 1'b0, 5'd0, 32'h00, 4'd0};
    tbl[4]  = '{1'b1, 5'd2, 1'b0, 4'd0, 32'h00, 4'd2, 1'b0, 5'd0, 32'h00, 4'd0};
    tbl[5]  = '{1'b1, 5'd3, 1'b0, 4'd0, 32'h00, 4'd3, 1'b0, 5'd0, 32'h00, 4'd0};
    tbl[6]  = '{1'b0, 5'd0, 1'b1, 4'd3, 32'h33, 4'd4, 1'b0, 5'd0, 32'h00, 4'd0};
    tbl[7]  = '{1'b0, 5'd0, 1'b1, 4'd1, 32'h11, 4'd4, 1'b0, 5'd0, 32'h00, 4'd0};
    tbl[8]  = '{1'b0, 5'd0, 1'b1, 4'd2, 32'h22, 4'd4, 1'b1, 5'd1, 32'h11, 4'd1};
    tbl[9]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h00, 4'd4, 1'b1, 5'd2, 32'h22, 4'd2};
    tbl[10] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h00, 4'd4, 1'b1, 5'd3, 32'h33, 4'd3};
    tbl[11] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h00, 4'd4, 1'b0, 5'd0, 32'h00, 4'd0};

    do_reset();

    // single round trip, then out-of-order completion retiring in order
    for (int i = 0; i < 12; i++) begin
      step(1, tbl[i].alloc, tbl[i].rd, 0, 0, 0, 0, tbl[i].cv, tbl[i].cid, tbl[i].cval, 0, 0);
      chk("tbl_alloc_id", pre_aid, tbl[i].e_aid);
      chk("tbl_commit", rdy_commit_rob_out, tbl[i].e_commit);
      if (tbl[i].e_commit) begin
        chk("tbl_dest", dest_rob_out, tbl[i].e_dest);
        chk("tbl_value", value_rob_out, tbl[i].e_val);
        chk("tbl_rob_id", rob_id_rob_out, tbl[i].e_id);
      end
    end

    // fill, overflow attempt, wrap-around reuse of id 0
    do_reset();
    for (int i = 0; i < 16; i++) alloc(5'(i + 1), 0, 0);
    chk("full_after_16", full_dp_out, 1);
    chk("alloc_id_after_16", alloc_id_dp_out, 0);
    alloc(5'd20, 0, 0);
    chk("alloc_id_after_17th", alloc_id_dp_out, 0);
    chk("full_after_17th", full_dp_out, 1);
    cdb(4'd0, 32'hC0DE, 0, 0);
    idle();
    chk("wrap_commit_id", rob_id_rob_out, 0);
    chk("full_after_commit", full_dp_out, 0);
    alloc(5'd9, 0, 0);
    chk("wrap_reuse_id0", pre_aid, 0);
    chk("full_after_reuse", full_dp_out, 1);

    // mispredict at head flushes younger entries and same-cycle alloc/CDB
    do_reset();
    alloc(5'd0, 1, 0);
    alloc(5'd5, 0, 0);
    alloc(5'd6, 0, 0);
    cdb(4'd0, 32'h0, 1, 32'h1000);
    step(1, 1, 5'd7, 0, 0, 0, 0, 1, 4'd1, 32'h99, 0, 0);
    chk("mis_refresh", refresh_rob_cdb_out, 1);
    chk("mis_pc", pc_redirect_out, 32'h1000);
    chk("mis_no_wr_rd0", rdy_commit_rob_out, 0);
    idle();
    chk("flush_alloc_id", pre_aid, 0);
    chk("flush_full", pre_full, 0);
    chk("refresh_one_cycle", refresh_rob_cdb_out, 0);
    cdb(4'd1, 32'h77, 0, 0);
    idle();
    chk("flushed_no_commit", rdy_commit_rob_out, 0);
    // JALR-like: write-back and redirect together
    alloc(5'd1, 1, 1);
    cdb(4'd0, 32'h44, 0, 32'h2000);
    idle();
    chk("jalr_commit", rdy_commit_rob_out, 1);
    chk("jalr_refresh", refresh_rob_cdb_out, 1);

    // operand bypass from the CDB in the same cycle
    do_reset();
    for (int i = 0; i < 6; i++) alloc(5'(i + 1), 0, 0);
    step(1, 0, 0, 0, 0, 4'd5, 4'd4, 1, 4'd5, 32'hAB, 0, 0);
    chk("fwd_rs1_ready", pre_r1, 1);
    chk("fwd_rs1_val", pre_v1, 32'hAB);
    chk("fwd_rs2_not_ready", pre_r2, 0);

    // global stall holds a ready head, then mid-stream reset
    do_reset();
    alloc(5'd7, 0, 0);
    cdb(4'd0, 32'h77, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 5'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("stall_no_commit", rdy_commit_rob_out, 0);
    end
    idle();
    chk("stall_release_commit", rdy_commit_rob_out, 1);
    chk("stall_release_value", value_rob_out, 32'h77);
    alloc(5'd3, 0, 0);
    alloc(5'd4, 0, 0);
    cdb(4'd1, 32'h12, 0, 0);
    do_reset();

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      bit          r, a, br, pt, cv, tk;
      logic [3:0]  cid;
      r  = ($urandom_range(0, 9) != 0);
      a  = ($urandom_range(0, 9) < 6);
      br = ($urandom_range(0, 5) == 0);
      pt = $urandom_range(0, 1);
      tk = $urandom_range(0, 1);
      cv = 0; cid = 4'($urandom_range(0, 15));
      if (mq.size() > 0 && $urandom_range(0, 9) < 6) begin
        cv  = 1;
        cid = 4'(mq[$urandom_range(0, mq.size() - 1)].id);
      end else if ($urandom_range(0, 9) == 0) begin
        cv = 1;
      end
      step(r, a, 5'($urandom_range(0, 31)), br, pt, 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), cv, cid, $urandom, tk, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
